// File: rtl/nibble_frame_rx_pkg.sv
// nibble_frame_rx_pkg
// Types and constants shared by the nibble frame receiver and its helpers.
//   state_t      : receiver FSM states
//   SYNC_DEFAULT : default sync word, oldest bit in [3]
//   BIT_CNT_W    : width of the data bit counter used while collecting
package nibble_frame_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_DEFAULT = 4'b1011;
    localparam int         BIT_CNT_W    = 2;

endpackage

// File: rtl/nibble_frame_rx_sat_counter.sv
// sat_counter
// Up-counter that holds at its all-ones value instead of wrapping.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset (clears q)
//   inc   : count enable, one increment per clock while high
//   q     : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/nibble_frame_rx.sv
// nibble_frame_rx
// Hunts for a 4-bit sync word in the window from an upstream 4-bit shift
// register, collects the following data nibble, optionally checks one
// even-parity bit, and presents the nibble with a one-cycle valid strobe.
// Saturating good-frame and parity-error counters are kept for status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | compare window against SYNC every clock
// COLLECT | waiting for four fresh data bits to fill the window
// PARITY  | data nibble held in shadow, next bit is the parity bit
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   win        : shift window, win[0] newest bit, win[3] oldest
//   data       : last accepted nibble, MSB = first data bit received
//   data_valid : one-cycle pulse when data updates
//   par_err    : one-cycle pulse on parity failure
//   locked     : high while in COLLECT or PARITY
//   frame_cnt  : saturating count of accepted frames
//   err_cnt    : saturating count of parity failures
module nibble_frame_rx
    import nibble_frame_rx_pkg::*;
#(
    parameter logic [3:0] SYNC      = SYNC_DEFAULT,
    parameter int         PARITY_EN = 1,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       win,
    output logic [3:0]       data,
    output logic             data_valid,
    output logic             par_err,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = {BIT_CNT_W{1'b1}};

    state_t               r_state;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic [3:0]           r_shadow;
    logic [3:0]           r_data;
    logic                 r_data_valid;
    logic                 r_par_err;
    logic                 r_locked;

    logic w_nibble_done;
    logic w_parity_ok;
    logic w_frame_inc;
    logic w_err_inc;

    // Once the counter reaches its last value the window holds exactly the
    // four data bits that followed the sync word.
    assign w_nibble_done = (r_state == COLLECT) && (r_cnt == LAST_BIT);

    // Even parity over data plus parity bit.
    assign w_parity_ok = ~((^r_shadow) ^ win[0]);

    // Counter strobes are decoded from the same conditions that raise the
    // registered pulses, so counters and pulses move on the same edge.
    assign w_frame_inc = (w_nibble_done && (PARITY_EN == 0)) ||
                         ((r_state == PARITY) && w_parity_ok);
    assign w_err_inc   = (r_state == PARITY) && !w_parity_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            case (r_state)
                HUNT: begin
                    // An X in the window makes the compare unknown, which
                    // falls through as a non-match.
                    if (win == SYNC) begin
                        r_state  <= COLLECT;
                        r_cnt    <= '0;
                        r_locked <= 1'b1;
                    end
                end
                COLLECT: begin
                    // Sync-looking data is ignored here; only the counter
                    // decides when the nibble is complete.
                    if (r_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            r_shadow <= win;
                            r_state  <= PARITY;
                        end else begin
                            r_data       <= win;
                            r_data_valid <= 1'b1;
                            r_state      <= HUNT;
                            r_locked     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_parity_ok) begin
                        r_data       <= r_shadow;
                        r_data_valid <= 1'b1;
                    end else begin
                        r_par_err <= 1'b1;
                    end
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
                default: begin
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_frame_inc),
        .q     (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err_inc),
        .q     (err_cnt)
    );

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign locked     = r_locked;

endmodule
